// File: rtl/cas_encoder.sv
// FSK cassette encoder: each byte is sent LSB first, one full square-wave cycle per bit.
// Optional `CAS_BYTECOUNT_EN adds a 16-bit count of accepted bytes.
//
// state | meaning
// IDLE  | waiting for a byte, cas_out low
// HIGH  | first half of the current bit cycle, cas_out high
// LOW   | second half of the current bit cycle, cas_out low
module cas_encoder #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD0_HZ = 1200,
  parameter int BAUD1_HZ = 2400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cas_out,
  output logic       busy
`ifdef CAS_BYTECOUNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam int HALF0 = CLK_HZ / (2 * BAUD0_HZ);
  localparam int HALF1 = CLK_HZ / (2 * BAUD1_HZ);
  localparam int CW    = $clog2(HALF0 + 1);
  localparam logic [CW-1:0] H0_M1 = CW'(HALF0 - 1);
  localparam logic [CW-1:0] H1_M1 = CW'(HALF1 - 1);

  if (HALF1 < 2) begin : g_bad_params
    $error("cas_encoder: HALF1 must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    in_ready = motor & ((state_q == IDLE) |
                        ((state_q == LOW) & (cnt_q == '0) & (idx_q == 3'd7)));
    accept   = in_valid & in_ready;

    if (!motor) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d = in_data;
            idx_d   = '0;
            cnt_d   = in_data[0] ? H1_M1 : H0_M1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            cnt_d   = shreg_q[0] ? H1_M1 : H0_M1;
            state_d = LOW;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx_q != 3'd7) begin
            shreg_d = {1'b0, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            cnt_d   = shreg_q[1] ? H1_M1 : H0_M1;
            state_d = HIGH;
          end else if (accept) begin
            // back-to-back byte: start its high phase with no idle gap
            shreg_d = in_data;
            idx_d   = '0;
            cnt_d   = in_data[0] ? H1_M1 : H0_M1;
            state_d = HIGH;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cas_out = (state_q == HIGH);
  assign busy    = (state_q != IDLE);

`ifdef CAS_BYTECOUNT_EN
  always_ff @(posedge clk) begin
    if (reset)       byte_count <= '0;
    else if (accept) byte_count <= byte_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cas_encoder.sv
// Scoreboard bench for cas_encoder: each accepted byte pushes its expected per-cycle
// waveform; a negedge monitor pops and compares cas_out, busy, in_ready (and byte_count).
module tb_cas_encoder;

  localparam int CLK_HZ = 24000;
  localparam int B0     = 1200;
  localparam int B1     = 2400;
  localparam int H0     = CLK_HZ / (2 * B0);
  localparam int H1     = CLK_HZ / (2 * B1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       motor = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, cas_out, busy;
`ifdef CAS_BYTECOUNT_EN
  logic [15:0] byte_count;
`endif

  cas_encoder #(.CLK_HZ(CLK_HZ), .BAUD0_HZ(B0), .BAUD1_HZ(B1)) dut (
    .clk(clk),
    .reset(reset),
    .motor(motor),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cas_out(cas_out),
    .busy(busy)
`ifdef CAS_BYTECOUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  logic        expq[$];
  logic [15:0] mcnt = 16'd0;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          last_acc;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // expected waveform of one byte: LSB first, each bit H high cycles then H low cycles
  task automatic push_byte(input logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      int h;
      h = d[b] ? H1 : H0;
      for (int i = 0; i < h; i++) expq.push_back(1'b1);
      for (int i = 0; i < h; i++) expq.push_back(1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic e, eb;
      if (expq.size() != 0) begin
        e  = expq.pop_front();
        eb = 1'b1;
      end else begin
        e  = 1'b0;
        eb = 1'b0;
      end
      chk("cas_out", {15'd0, cas_out}, {15'd0, e});
      chk("busy", {15'd0, busy}, {15'd0, eb});
`ifdef CAS_BYTECOUNT_EN
      chk("byte_count", byte_count, mcnt);
`endif
      #2;
      if (!reset)
        chk("in_ready", {15'd0, in_ready}, {15'd0, motor & (expq.size() == 0)});
    end
  end

  // one clock of stimulus; acceptance is decided from the model, not the DUT
  task automatic step(input logic m, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    #1;
    motor    = m;
    in_valid = v;
    in_data  = d;
    reset    = r;
    last_acc = !r && m && v && (expq.size() == 0);
    @(posedge clk);
    if (r) begin
      expq.delete();
      mcnt = 16'd0;
    end else if (!m) begin
      expq.delete();
    end else if (last_acc) begin
      push_byte(d);
      mcnt = mcnt + 16'd1;
    end
  endtask

  task automatic idle_cycles(input int n, input logic m);
    for (int i = 0; i < n; i++) step(m, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int nacc;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    mon_en = 1'b1;

    // motor off: nothing accepted, output idle
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);

    // single byte 8'h01: 150 busy cycles
    step(1'b1, 1'b1, 8'h01, 1'b0);
    idle_cycles(160, 1'b1);

    // back-to-back 8'h55 then 8'hFF with in_valid held
    nacc = 0;
    for (int i = 0; i < 300 && nacc < 2; i++) begin
      step(1'b1, 1'b1, (nacc == 0) ? 8'h55 : 8'hFF, 1'b0);
      if (last_acc) nacc++;
    end
    chk("b2b_accepts", 16'(nacc), 16'd2);
    idle_cycles(90, 1'b1);

    // motor drop in the third bit of 8'h00, then a clean 8'hFF
    step(1'b1, 1'b1, 8'h00, 1'b0);
    idle_cycles(45, 1'b1);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    idle_cycles(3, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    idle_cycles(90, 1'b1);

    // reset during a high phase
    step(1'b1, 1'b1, 8'($urandom), 1'b0);
    idle_cycles(3, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    idle_cycles(5, 1'b1);

    // three bytes back-to-back
    nacc = 0;
    for (int i = 0; i < 600 && nacc < 3; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      if (last_acc) nacc++;
    end
    chk("three_accepts", 16'(nacc), 16'd3);
    idle_cycles(170, 1'b1);

    // randomized traffic with occasional motor drops and resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) != 0, ($urandom % 3) != 0, 8'($urandom), ($urandom % 700) == 0);
    end
    idle_cycles(170, 1'b1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
